// File: rtl/eu_iqueue_banked.sv
// Single-write circular FIFO bank; occupancy is tracked by the owning queue.
// Latency: a write is readable at head_dat from the next cycle; head_dat is read combinationally from storage.
// Backpressure: none here; the owner guarantees no push when full and no pop when empty.
module eu_iq_bank_fifo #(
  parameter int W          = 64,
  parameter int LOG2_DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_vld,
  output logic [W-1:0] head_dat
);
  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [W-1:0]          mem [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_idx;
  logic [LOG2_DEPTH-1:0] rd_idx;

  // Pointer update; indices wrap naturally at DEPTH. Flush behaves like reset.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_idx <= '0;
      rd_idx <= '0;
    end else begin
      if (push_vld) wr_idx <= wr_idx + 1'b1;
      if (pop_vld)  rd_idx <= rd_idx + 1'b1;
    end
  end

  // Storage is never cleared; stale contents are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (push_vld) mem[wr_idx] <= push_dat;
  end

  assign head_dat = mem[rd_idx];
endmodule

// EU issue queue: filters and compacts dispatch lanes for this EU, stripes them over banks, issues in order.
// Latency: an entry accepted in cycle t is visible on out_* in cycle t+1 at the earliest (no empty bypass).
// Backpressure: whole batch rejected via is_full_o when free space is short; out_* holds while out_ready_i is low.
module eu_iqueue_banked #(
  parameter int DATA_WIDTH          = 64,
  parameter int LOG2_BANK_DEPTH     = 2,
  parameter int LOG2_NUM_BANKS      = 2,
  parameter int NUM_DISPATCH        = 4,
  parameter int LOG2_NUM_EXEC_UNITS = 2,
  parameter int EU_IDX              = 0
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_DISPATCH*DATA_WIDTH-1:0]          disp_data_i,
  input  logic [NUM_DISPATCH-1:0]                     disp_valid_i,
  input  logic [NUM_DISPATCH*LOG2_NUM_EXEC_UNITS-1:0] disp_euidx_i,
  output logic                                        is_full_o,
  input  logic                                        flush_i,
  output logic [DATA_WIDTH-1:0]                       out_data_o,
  output logic                                        out_valid_o,
  input  logic                                        out_ready_i,
  output logic [LOG2_NUM_BANKS+LOG2_BANK_DEPTH:0]     count_o
);
  localparam int NUM_BANKS = 1 << LOG2_NUM_BANKS;
  localparam int CW        = LOG2_NUM_BANKS + LOG2_BANK_DEPTH + 1;
  localparam logic [CW-1:0] CAP = CW'(NUM_BANKS << LOG2_BANK_DEPTH);
  localparam logic [LOG2_NUM_EXEC_UNITS-1:0] EU_SEL = LOG2_NUM_EXEC_UNITS'(EU_IDX);

  if (NUM_DISPATCH > NUM_BANKS) begin : g_bad_cfg
    $error("eu_iqueue_banked: NUM_DISPATCH must not exceed NUM_BANKS");
  end

  logic [NUM_DISPATCH-1:0]   rel;
  logic [CW-1:0]             n_rel;
  logic [CW-1:0]             count;
  logic [CW-1:0]             free_slots;
  logic                      accept;
  logic                      pop;
  logic [LOG2_NUM_BANKS-1:0] wr_bank;
  logic [LOG2_NUM_BANKS-1:0] rd_bank;
  logic [NUM_BANKS-1:0]      bank_push;
  logic [NUM_BANKS-1:0]      bank_pop;
  logic [DATA_WIDTH-1:0]     bank_wr_dat [NUM_BANKS];
  logic [DATA_WIDTH-1:0]     bank_head   [NUM_BANKS];

  // Lane filter: which lanes target this EU, and how many.
  always_comb begin
    rel   = '0;
    n_rel = '0;
    for (int k = 0; k < NUM_DISPATCH; k++) begin
      rel[k] = disp_valid_i[k] &&
               (disp_euidx_i[k*LOG2_NUM_EXEC_UNITS +: LOG2_NUM_EXEC_UNITS] == EU_SEL);
      n_rel  = n_rel + CW'(rel[k]);
    end
  end

  // Full check uses registered count only, so a same-cycle pop never makes room.
  assign free_slots  = CAP - count;
  assign is_full_o   = (n_rel > free_slots) && !flush_i;
  assign accept      = (n_rel != '0) && !is_full_o && !flush_i;
  assign out_valid_o = (count != '0);
  assign pop         = out_valid_o && out_ready_i && !flush_i;

  // Compaction: the j-th relevant lane goes to bank wr_bank+j; NUM_DISPATCH <= NUM_BANKS keeps targets distinct.
  always_comb begin
    logic [LOG2_NUM_BANKS-1:0] slot;
    logic [LOG2_NUM_BANKS-1:0] tgt;
    bank_push = '0;
    slot      = '0;
    tgt       = '0;
    for (int b = 0; b < NUM_BANKS; b++) bank_wr_dat[b] = '0;
    for (int k = 0; k < NUM_DISPATCH; k++) begin
      if (rel[k]) begin
        tgt              = wr_bank + slot;
        bank_push[tgt]   = accept;
        bank_wr_dat[tgt] = disp_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        slot             = slot + 1'b1;
      end
    end
  end

  // Issue side: only the bank under rd_bank advances its head.
  always_comb begin
    bank_pop          = '0;
    bank_pop[rd_bank] = pop;
  end

  assign out_data_o = bank_head[rd_bank];
  assign count_o    = count;

  // Global occupancy and bank-rotation pointers; flush has reset semantics and wins over accept/pop.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      count   <= '0;
      wr_bank <= '0;
      rd_bank <= '0;
    end else begin
      count <= count + (accept ? n_rel : '0) - CW'(pop);
      if (accept) wr_bank <= wr_bank + n_rel[LOG2_NUM_BANKS-1:0];
      if (pop)    rd_bank <= rd_bank + 1'b1;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    eu_iq_bank_fifo #(
      .W          (DATA_WIDTH),
      .LOG2_DEPTH (LOG2_BANK_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush_i),
      .push_vld (bank_push[b]),
      .push_dat (bank_wr_dat[b]),
      .pop_vld  (bank_pop[b]),
      .head_dat (bank_head[b])
    );
  end
endmodule

// File: tb/tb_eu_iqueue_banked.sv
// Bench for eu_iqueue_banked: directed scenarios plus randomized traffic against a queue-based model.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later, well before the rising edge.
// The model is a single in-order queue of accepted entries; its size is the expected occupancy.
module tb_eu_iqueue_banked;
  localparam int DW  = 64;
  localparam int ND  = 4;
  localparam int LNE = 2;
  localparam int CW  = 5;
  localparam int CAP = 16;
  localparam int EU  = 0;

  logic               clk = 1'b0;
  logic               reset;
  logic [ND*DW-1:0]   disp_data_i;
  logic [ND-1:0]      disp_valid_i;
  logic [ND*LNE-1:0]  disp_euidx_i;
  logic               is_full_o;
  logic               flush_i;
  logic [DW-1:0]      out_data_o;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [CW-1:0]      count_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] mq[$];
  int  m_nrel;
  bit  m_full, m_accept, m_pop;

  eu_iqueue_banked dut (
    .clk          (clk),
    .reset        (reset),
    .disp_data_i  (disp_data_i),
    .disp_valid_i (disp_valid_i),
    .disp_euidx_i (disp_euidx_i),
    .is_full_o    (is_full_o),
    .flush_i      (flush_i),
    .out_data_o   (out_data_o),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  function automatic bit is_rel(input int k);
    logic [LNE-1:0] e;
    e = disp_euidx_i[k*LNE +: LNE];
    return disp_valid_i[k] && (int'(e) == EU);
  endfunction

  task automatic clear_lanes();
    disp_valid_i = '0;
    disp_euidx_i = '0;
    disp_data_i  = '0;
  endtask

  task automatic set_lane(input int k, input bit v, input int eu, input logic [DW-1:0] d);
    logic [LNE-1:0] e;
    e = LNE'(eu);
    disp_valid_i[k]              = v;
    disp_euidx_i[k*LNE +: LNE]   = e;
    disp_data_i[k*DW +: DW]      = d;
  endtask

  // Expected handshake decisions for the inputs currently driven.
  task automatic model_eval();
    m_nrel = 0;
    for (int k = 0; k < ND; k++) if (is_rel(k)) m_nrel++;
    m_full   = (m_nrel > CAP - mq.size()) && !flush_i;
    m_accept = (m_nrel != 0) && !m_full && !flush_i;
    m_pop    = (mq.size() != 0) && out_ready_i && !flush_i;
  endtask

  // One clock: model decides from pre-edge inputs, then queue updates at the edge.
  task automatic tick();
    model_eval();
    @(posedge clk);
    if (reset || flush_i) begin
      mq.delete();
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_accept)
        for (int k = 0; k < ND; k++)
          if (is_rel(k)) mq.push_back(disp_data_i[k*DW +: DW]);
    end
    @(negedge clk);
  endtask

  task automatic push_n(input int n, input logic [DW-1:0] base);
    clear_lanes();
    for (int k = 0; k < n; k++) set_lane(k, 1'b1, EU, base + DW'(k));
    tick();
    clear_lanes();
  endtask

  task automatic test_reset();
    reset = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0; clear_lanes();
    tick(); tick();
    reset = 1'b0;
    n_tests++;
    if (count_o !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    n_tests++;
    if (out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
    for (int k = 0; k < ND; k++) set_lane(k, 1'b1, EU, 64'h0);
    #1;
    n_tests++;
    if (is_full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full4 got=%b exp=0", is_full_o); end
    clear_lanes();
  endtask

  task automatic test_basic();
    set_lane(0, 1'b1, 1, 64'hA); set_lane(1, 1'b1, 0, 64'hB);
    set_lane(2, 1'b1, 2, 64'hC); set_lane(3, 1'b1, 0, 64'hD);
    out_ready_i = 1'b0;
    #1;
    n_tests++;
    if (is_full_o !== 1'b0) begin n_fail++; $display("FAIL basic_full got=%b exp=0", is_full_o); end
    tick();
    clear_lanes();
    #1;
    n_tests++;
    if (count_o !== 5'd2) begin n_fail++; $display("FAIL basic_count got=%0d exp=2", count_o); end
    n_tests++;
    if (out_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%b exp=1", out_valid_o); end
    n_tests++;
    if (out_data_o !== 64'hB) begin n_fail++; $display("FAIL basic_head got=%0h exp=b", out_data_o); end
    out_ready_i = 1'b1;
    tick();
    #1;
    n_tests++;
    if (out_data_o !== 64'hD) begin n_fail++; $display("FAIL basic_second got=%0h exp=d", out_data_o); end
    tick();
    #1;
    n_tests++;
    if (count_o !== 5'd0) begin n_fail++; $display("FAIL basic_drain got=%0d exp=0", count_o); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_full_retry();
    out_ready_i = 1'b0;
    push_n(4, 64'h100); push_n(4, 64'h110); push_n(4, 64'h120); push_n(2, 64'h130);
    #1;
    n_tests++;
    if (count_o !== 5'd14) begin n_fail++; $display("FAIL full_fill got=%0d exp=14", count_o); end
    for (int k = 0; k < 3; k++) set_lane(k, 1'b1, EU, 64'h200 + DW'(k));
    set_lane(3, 1'b1, 1, 64'h2FF);
    #1;
    n_tests++;
    if (is_full_o !== 1'b1) begin n_fail++; $display("FAIL full_reject got=%b exp=1", is_full_o); end
    tick();
    n_tests++;
    if (count_o !== 5'd14) begin n_fail++; $display("FAIL full_hold got=%0d exp=14", count_o); end
    out_ready_i = 1'b1;
    #1;
    n_tests++;
    if (is_full_o !== 1'b1) begin n_fail++; $display("FAIL full_pop_no_room got=%b exp=1", is_full_o); end
    tick();
    out_ready_i = 1'b0;
    #1;
    n_tests++;
    if (count_o !== 5'd13) begin n_fail++; $display("FAIL full_after_pop got=%0d exp=13", count_o); end
    n_tests++;
    if (is_full_o !== 1'b0) begin n_fail++; $display("FAIL full_retry got=%b exp=0", is_full_o); end
    tick();
    clear_lanes();
    #1;
    n_tests++;
    if (count_o !== 5'd16) begin n_fail++; $display("FAIL full_16 got=%0d exp=16", count_o); end
    out_ready_i = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      n_tests++;
      if (out_valid_o !== 1'b1 || out_data_o !== mq[0]) begin
        n_fail++; $display("FAIL full_drain[%0d] got=%b/%0h exp=1/%0h", i, out_valid_o, out_data_o, mq[0]);
      end
      tick();
    end
    out_ready_i = 1'b0;
  endtask

  task automatic test_wrap();
    out_ready_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      clear_lanes();
      set_lane(int'($urandom_range(0, 3)), 1'b1, EU, DW'(i));
      tick();
      clear_lanes();
      #1;
      n_tests++;
      if (out_valid_o !== 1'b1 || out_data_o !== DW'(i) || count_o > 5'd1) begin
        n_fail++; $display("FAIL wrap[%0d] got=%b/%0h/%0d exp=1/%0h/<=1", i, out_valid_o, out_data_o, count_o, i);
      end
    end
    tick();
    n_tests++;
    if (count_o !== 5'd0) begin n_fail++; $display("FAIL wrap_empty got=%0d exp=0", count_o); end
    out_ready_i = 1'b0;
  endtask

  task automatic test_mixed_batches();
    logic [DW-1:0] exp_q[$];
    out_ready_i = 1'b0;
    clear_lanes();
    set_lane(0, 1'b1, 1, 64'hE0); set_lane(2, 1'b1, 0, 64'h12); set_lane(3, 1'b1, 3, 64'hE3);
    exp_q.push_back(64'h12);
    tick();
    clear_lanes();
    set_lane(0, 1'b1, 0, 64'h20); set_lane(1, 1'b1, 0, 64'h21); set_lane(2, 1'b1, 2, 64'hE2);
    set_lane(3, 1'b1, 0, 64'h23);
    exp_q.push_back(64'h20); exp_q.push_back(64'h21); exp_q.push_back(64'h23);
    tick();
    clear_lanes();
    set_lane(1, 1'b1, 0, 64'h31); set_lane(2, 1'b0, 0, 64'hEE); set_lane(3, 1'b1, 0, 64'h33);
    exp_q.push_back(64'h31); exp_q.push_back(64'h33);
    tick();
    clear_lanes();
    for (int k = 0; k < ND; k++) begin
      set_lane(k, 1'b1, 0, 64'h40 + DW'(k));
      exp_q.push_back(64'h40 + DW'(k));
    end
    tick();
    clear_lanes();
    #1;
    n_tests++;
    if (count_o !== 5'd10) begin n_fail++; $display("FAIL mixed_count got=%0d exp=10", count_o); end
    out_ready_i = 1'b1;
    foreach (exp_q[i]) begin
      #1;
      n_tests++;
      if (out_valid_o !== 1'b1 || out_data_o !== exp_q[i]) begin
        n_fail++; $display("FAIL mixed_order[%0d] got=%b/%0h exp=1/%0h", i, out_valid_o, out_data_o, exp_q[i]);
      end
      tick();
    end
    out_ready_i = 1'b0;
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    push_n(4, 64'h500); push_n(4, 64'h510); push_n(1, 64'h520);
    #1;
    n_tests++;
    if (count_o !== 5'd9) begin n_fail++; $display("FAIL flush_fill got=%0d exp=9", count_o); end
    set_lane(0, 1'b1, EU, 64'h5A0); set_lane(2, 1'b1, EU, 64'h5A2);
    flush_i = 1'b1; out_ready_i = 1'b1;
    #1;
    n_tests++;
    if (is_full_o !== 1'b0) begin n_fail++; $display("FAIL flush_full got=%b exp=0", is_full_o); end
    tick();
    flush_i = 1'b0; out_ready_i = 1'b0; clear_lanes();
    #1;
    n_tests++;
    if (count_o !== 5'd0 || out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_empty got=%0d/%b exp=0/0", count_o, out_valid_o);
    end
    set_lane(1, 1'b1, EU, 64'hFACE);
    tick();
    clear_lanes();
    #1;
    n_tests++;
    if (out_valid_o !== 1'b1 || out_data_o !== 64'hFACE || count_o !== 5'd1) begin
      n_fail++; $display("FAIL flush_next got=%b/%0h/%0d exp=1/face/1", out_valid_o, out_data_o, count_o);
    end
    out_ready_i = 1'b1;
    tick();
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready_i = 1'b0;
    push_n(4, 64'h700); push_n(3, 64'h710);
    #1;
    n_tests++;
    if (count_o !== 5'd7) begin n_fail++; $display("FAIL rst_mid_fill got=%0d exp=7", count_o); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if (count_o !== 5'd0 || out_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_empty got=%0d/%b exp=0/0", count_o, out_valid_o);
    end
    set_lane(3, 1'b1, EU, 64'hBEEF);
    tick();
    push_n(2, 64'h800);
    #1;
    n_tests++;
    if (out_valid_o !== 1'b1 || out_data_o !== 64'hBEEF) begin
      n_fail++; $display("FAIL rst_mid_first got=%b/%0h exp=1/beef", out_valid_o, out_data_o);
    end
    out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++;
      if (out_data_o !== mq[0]) begin n_fail++; $display("FAIL rst_mid_drain[%0d] got=%0h exp=%0h", i, out_data_o, mq[0]); end
      tick();
    end
    out_ready_i = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      clear_lanes();
      for (int k = 0; k < ND; k++)
        set_lane(k, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 1) != 0) ? EU : int'($urandom_range(0, 3)),
                 {$urandom(), $urandom()});
      out_ready_i = ($urandom_range(0, 3) == 0);
      flush_i     = ($urandom_range(0, 39) == 0);
      reset       = ($urandom_range(0, 79) == 0);
      #1;
      model_eval();
      if (!reset) begin
        n_tests++;
        if (is_full_o !== m_full) begin n_fail++; $display("FAIL rnd_full[%0d] got=%b exp=%b", c, is_full_o, m_full); end
      end
      n_tests++;
      if (count_o !== CW'(mq.size()) || out_valid_o !== (mq.size() != 0)) begin
        n_fail++; $display("FAIL rnd_occ[%0d] got=%0d/%b exp=%0d", c, count_o, out_valid_o, mq.size());
      end
      if (mq.size() != 0) begin
        n_tests++;
        if (out_data_o !== mq[0]) begin n_fail++; $display("FAIL rnd_head[%0d] got=%0h exp=%0h", c, out_data_o, mq[0]); end
      end
      tick();
    end
    reset = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0; clear_lanes();
  endtask

  initial begin
    reset = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0; clear_lanes();
    test_reset();
    test_basic();
    test_full_retry();
    test_wrap();
    test_mixed_batches();
    test_flush();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/eu_iqueue_banked.md
Name: eu_iqueue_banked

Overview:
Per-execution-unit instruction queue. It filters the parallel dispatch bus for lanes addressed to this EU and compacts those lanes with lane order preserved. Accepted entries are written round-robin across NUM_BANKS single-write FIFO banks and issued one per cycle, in dispatch order, through a valid/ready handshake. It is the next generation of the EU issue queue. New capabilities are all-or-nothing batch acceptance against true free space, a flush input, an occupancy output and a generic data width.

Parameters:
- DATA_WIDTH, 64, width of one queue entry.
- LOG2_BANK_DEPTH, 2, log2 of entries per bank.
- LOG2_NUM_BANKS, 2, log2 of bank count. NUM_BANKS = 2**LOG2_NUM_BANKS.
- NUM_DISPATCH, 4, dispatch lanes. Elaboration check: NUM_DISPATCH <= NUM_BANKS.
- LOG2_NUM_EXEC_UNITS, 2, width of the EU index.
- EU_IDX, 0, index of this EU.
- Derived: CAP = NUM_BANKS * 2**LOG2_BANK_DEPTH. CW = LOG2_NUM_BANKS + LOG2_BANK_DEPTH + 1.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous active-high reset.
- disp_data_i  input  NUM_DISPATCH*DATA_WIDTH  lane k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- disp_valid_i  input  NUM_DISPATCH  per-lane valid.
- disp_euidx_i  input  NUM_DISPATCH*LOG2_NUM_EXEC_UNITS  per-lane target EU.
- is_full_o  output  1  combinational; batch rejected this cycle, front end retries.
- flush_i  input  1  discard all contents.
- out_data_o  output  DATA_WIDTH  oldest entry.
- out_valid_o  output  1  queue non-empty.
- out_ready_i  input  1  consumer accepts out_data_o.
- count_o  output  CW  registered occupancy.

Behaviour:
- Relevant lane: rel[k] = disp_valid_i[k] & (euidx[k] == EU_IDX). n_rel = popcount(rel).
- is_full_o = (n_rel > CAP - count) & ~flush_i.
  - Uses the registered count; a same-cycle pop does not create space.
  - is_full_o is 0 whenever n_rel = 0.
- Accept when n_rel != 0 & ~is_full_o & ~flush_i. On accept:
  - the j-th lowest relevant lane is written to bank (wr_bank + j) mod NUM_BANKS;
  - wr_bank advances by n_rel, wrapping mod NUM_BANKS.
- Reject: nothing is written and no pointer changes. There are no partial accepts.
- Each bank is a circular FIFO with its own write and read index, each wrapping mod 2**LOG2_BANK_DEPTH.
- out_valid_o = (count != 0). out_data_o = head of bank rd_bank. out_data_o is don't-care when out_valid_o = 0.
- Pop when out_valid_o & out_ready_i & ~flush_i:
  - the head index of bank rd_bank increments;
  - rd_bank advances by 1 mod NUM_BANKS.
- count_next = count + (accept ? n_rel : 0) - (pop ? 1 : 0).
  - Simultaneous accept and pop in the same cycle is legal.
- Latency: an entry written in cycle t is visible on out_* in cycle t+1 at the earliest. There is no bypass when empty.
- Issue order equals dispatch order: across cycles, then by ascending lane within a cycle.
- flush_i:
  - dominates accept and pop in the same cycle;
  - next cycle: count = 0, every bank pointer = 0, wr_bank = rd_bank = 0, out_valid_o = 0.
- Reset (sync, active-high, also mid-operation): identical end state to flush, and count_o = 0.
  - out_valid_o = 0 from the first cycle after reset.
  - is_full_o = 0 for any legal input while empty.
- Bank storage is not cleared by reset or flush; only pointers and count are.
- Keeping out_valid_o high while out_ready_i is low holds out_data_o stable.

Test Plan:
- Reset, then lanes 0..3 valid with euidx {1,0,2,0}, data {A,B,C,D}, EU_IDX=0 -> is_full_o=0. Next cycle count_o=2, out_valid_o=1, out_data_o=B; after one pop, out_data_o=D.
- Fill 14 entries, then dispatch 3 relevant lanes -> is_full_o=1 and count stays 14. Pop 1 that same cycle -> still rejected. Next cycle count=13 and the retry of 3 is accepted -> count=16.
- Wrap test: stream 40 single-lane entries with values 0..39 and out_ready_i=1 continuously -> outputs 0..39 in order, one cycle after each push; count_o never exceeds 1.
- Mixed batches of 1, 3, 2 and 4 relevant lanes at non-contiguous positions -> issue order matches lane order across batches; wr_bank ends at (1+3+2+4) mod 4 = 2.
- Count 9, assert flush_i together with a valid 2-lane dispatch and out_ready_i=1 -> next cycle count_o=0 and out_valid_o=0. A following single push with value X issues X.
- Assert reset while count=7 and out_ready_i=0 -> next cycle count_o=0 and out_valid_o=0. Next dispatch goes to bank 0 and issues first.
